// File: rtl/dlsc_stereobm_multipipe_wta.sv
// Stereo block-matching core: windowed SAD over MULT_D disparities x MULT_R rows,
// per-row winner-take-all. Four stages, and the whole pipe stalls on output backpressure.

module dlsc_stereobm_multipipe_wta #(
   parameter int MULT_D    = 8,
   parameter int MULT_R    = 2,
   parameter int SAD       = 9,
   parameter int DATA      = 9,
   parameter int SAD_BITS  = 16,
   parameter int DISP_BITS = 8,
   parameter int SAD_R     = SAD + MULT_R - 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic                        in_first,
   input  logic [DISP_BITS-1:0]        in_disp_base,
   input  logic [DATA*SAD_R-1:0]       in_left,
   input  logic [DATA*SAD_R-1:0]       in_right,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [DISP_BITS*MULT_R-1:0] out_disp,
   output logic [SAD_BITS*MULT_R-1:0]  out_sad
);

   localparam int CMAX     = SAD + MULT_D - 1;
   localparam int CNT_BITS = $clog2(CMAX + 1);

   logic                        w_en;
   logic                        r_out_valid;
   logic [DISP_BITS*MULT_R-1:0] r_out_disp;
   logic [SAD_BITS*MULT_R-1:0]  r_out_sad;

   logic [DATA*SAD_R-1:0] r_casc [MULT_D];
   logic [DATA*SAD_R-1:0] w_rc   [MULT_D];
   logic [CNT_BITS-1:0]   r_cnt, w_cnt_nxt;
   logic [DISP_BITS-1:0]  r_base, w_base_nxt;

   logic [DATA-1:0]       w_ad [MULT_D][SAD_R];
   logic [DATA-1:0]       r_ad [MULT_D][SAD_R];
   logic                  r_v1, r_f1, r_e1;
   logic [DISP_BITS-1:0]  r_b1;

   logic [SAD_BITS-1:0]   w_col [MULT_D][MULT_R];
   logic [SAD_BITS-1:0]   r_col [MULT_D][MULT_R];
   logic                  r_v2, r_f2, r_e2;
   logic [DISP_BITS-1:0]  r_b2;

   logic [SAD_BITS-1:0]   r_hist [MULT_D][MULT_R][SAD];
   logic [SAD_BITS-1:0]   r_acc  [MULT_D][MULT_R];
   logic                  r_v3, r_e3;
   logic [DISP_BITS-1:0]  r_b3;

   logic [SAD_BITS-1:0]   w_best [MULT_R];
   logic [DISP_BITS-1:0]  w_bd   [MULT_R];

   // Every stage advances together; only a held output result stops the pipe.
   assign w_en      = !(r_out_valid && !out_ready);
   assign in_ready  = w_en;
   assign out_valid = r_out_valid;
   assign out_disp  = r_out_disp;
   assign out_sad   = r_out_sad;

   // w_rc[d] is the right column d beats behind the current one.
   always_comb begin
      w_rc[0] = in_right;
      for (int d = 1; d < MULT_D; d++) w_rc[d] = r_casc[d-1];
   end

   always_comb begin
      for (int d = 0; d < MULT_D; d++)
         for (int i = 0; i < SAD_R; i++)
            w_ad[d][i] = (in_left[i*DATA +: DATA] > w_rc[d][i*DATA +: DATA]) ?
                         in_left[i*DATA +: DATA] - w_rc[d][i*DATA +: DATA] :
                         w_rc[d][i*DATA +: DATA] - in_left[i*DATA +: DATA];
   end

   always_comb begin
      w_cnt_nxt  = r_cnt;
      w_base_nxt = r_base;
      if (in_first) begin
         w_cnt_nxt  = CNT_BITS'(1);
         w_base_nxt = in_disp_base;
      end else if (r_cnt != CNT_BITS'(CMAX)) begin
         w_cnt_nxt = r_cnt + CNT_BITS'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= '0;
         r_base <= '0;
         r_v1   <= 1'b0;
         r_f1   <= 1'b0;
         r_e1   <= 1'b0;
         r_b1   <= '0;
         for (int d = 0; d < MULT_D; d++) begin
            r_casc[d] <= '0;
            for (int i = 0; i < SAD_R; i++) r_ad[d][i] <= '0;
         end
      end else if (w_en) begin
         r_v1 <= in_valid;
         if (in_valid) begin
            r_cnt  <= w_cnt_nxt;
            r_base <= w_base_nxt;
            r_f1   <= in_first;
            r_e1   <= (w_cnt_nxt == CNT_BITS'(CMAX));
            r_b1   <= w_base_nxt;
            for (int d = 0; d < MULT_D; d++) begin
               r_casc[d] <= w_rc[d];
               for (int i = 0; i < SAD_R; i++) r_ad[d][i] <= w_ad[d][i];
            end
         end
      end
   end

   always_comb begin
      for (int d = 0; d < MULT_D; d++)
         for (int r = 0; r < MULT_R; r++) begin
            w_col[d][r] = '0;
            for (int k = 0; k < SAD; k++) w_col[d][r] = w_col[d][r] + SAD_BITS'(r_ad[d][r+k]);
         end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v2 <= 1'b0;
         r_f2 <= 1'b0;
         r_e2 <= 1'b0;
         r_b2 <= '0;
         for (int d = 0; d < MULT_D; d++)
            for (int r = 0; r < MULT_R; r++) r_col[d][r] <= '0;
      end else if (w_en) begin
         r_v2 <= r_v1;
         if (r_v1) begin
            r_f2 <= r_f1;
            r_e2 <= r_e1;
            r_b2 <= r_b1;
            for (int d = 0; d < MULT_D; d++)
               for (int r = 0; r < MULT_R; r++) r_col[d][r] <= w_col[d][r];
         end
      end
   end

   // The pass-start flag travels with its beat, so older beats finish their own window first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v3 <= 1'b0;
         r_e3 <= 1'b0;
         r_b3 <= '0;
         for (int d = 0; d < MULT_D; d++)
            for (int r = 0; r < MULT_R; r++) begin
               r_acc[d][r] <= '0;
               for (int k = 0; k < SAD; k++) r_hist[d][r][k] <= '0;
            end
      end else if (w_en) begin
         r_v3 <= r_v2;
         if (r_v2) begin
            r_e3 <= r_e2;
            r_b3 <= r_b2;
            for (int d = 0; d < MULT_D; d++)
               for (int r = 0; r < MULT_R; r++) begin
                  r_hist[d][r][0] <= r_col[d][r];
                  if (r_f2) begin
                     r_acc[d][r] <= r_col[d][r];
                     for (int k = 1; k < SAD; k++) r_hist[d][r][k] <= '0;
                  end else begin
                     r_acc[d][r] <= r_acc[d][r] + r_col[d][r] - r_hist[d][r][SAD-1];
                     for (int k = 1; k < SAD; k++) r_hist[d][r][k] <= r_hist[d][r][k-1];
                  end
               end
         end
      end
   end

   // Strict less-than keeps the lowest disparity on ties.
   always_comb begin
      for (int r = 0; r < MULT_R; r++) begin
         w_best[r] = r_acc[0][r];
         w_bd[r]   = '0;
         for (int d = 1; d < MULT_D; d++)
            if (r_acc[d][r] < w_best[r]) begin
               w_best[r] = r_acc[d][r];
               w_bd[r]   = DISP_BITS'(d);
            end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_disp  <= '0;
         r_out_sad   <= '0;
      end else if (w_en) begin
         r_out_valid <= r_v3 && r_e3;
         if (r_v3 && r_e3) begin
            for (int r = 0; r < MULT_R; r++) begin
               r_out_disp[r*DISP_BITS +: DISP_BITS] <= r_b3 + w_bd[r];
               r_out_sad[r*SAD_BITS +: SAD_BITS]    <= w_best[r];
            end
         end
      end
   end

endmodule

// File: tb/tb_dlsc_stereobm_multipipe_wta.sv
// Directed bench for dlsc_stereobm_multipipe_wta: hand-derived patterns, an expected-result
// queue filled at acceptance time, and immediate assertions at each check point.

module tb_dlsc_stereobm_multipipe_wta;

   localparam int MULT_D = 8, MULT_R = 2, SAD = 9, DATA = 9;
   localparam int SAD_BITS = 16, DISP_BITS = 8, SAD_R = SAD + MULT_R - 1;
   localparam int CMAX = SAD + MULT_D - 1;
   localparam int CW = DATA * SAD_R;

   logic                        clk = 1'b0;
   logic                        rst_n;
   logic                        in_valid, in_ready, in_first;
   logic [DISP_BITS-1:0]        in_disp_base;
   logic [CW-1:0]               in_left, in_right;
   logic                        out_valid, out_ready;
   logic [DISP_BITS*MULT_R-1:0] out_disp;
   logic [SAD_BITS*MULT_R-1:0]  out_sad;

   always #5 clk = ~clk;

   dlsc_stereobm_multipipe_wta #(
      .MULT_D(MULT_D), .MULT_R(MULT_R), .SAD(SAD), .DATA(DATA),
      .SAD_BITS(SAD_BITS), .DISP_BITS(DISP_BITS)
   ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first),
      .in_disp_base(in_disp_base), .in_left(in_left), .in_right(in_right),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_disp(out_disp), .out_sad(out_sad)
   );

   typedef struct {
      logic [7:0]  d0, d1;
      logic [15:0] s0, s1;
      int          c;
   } exp_t;

   exp_t        q[$];
   int          n_cmp = 0, n_fail = 0, cyc = 0;
   int          m_cnt, e_d, e_s0, e_s1, stall_left;
   logic [7:0]  m_base;
   bit          chk_lat, p_stall;
   logic [15:0] p_disp;
   logic [31:0] p_sad;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [CW-1:0] col_const(input int v);
      logic [CW-1:0] c;
      for (int i = 0; i < SAD_R; i++) c[i*DATA +: DATA] = DATA'(v);
      return c;
   endfunction

   function automatic logic [CW-1:0] col_ramp(input int n);
      logic [CW-1:0] c;
      for (int i = 0; i < SAD_R; i++) c[i*DATA +: DATA] = DATA'((n*37 + i*11) % 512);
      return c;
   endfunction

   function automatic logic [CW-1:0] col_r5();
      logic [CW-1:0] c;
      c = col_const(100);
      c[DATA-1:0] = DATA'(110);
      return c;
   endfunction

   task automatic step(input logic v, input logic f, input logic [7:0] b,
                       input logic [CW-1:0] l, input logic [CW-1:0] r, output bit accd);
      logic rdy;
      exp_t e;
      rdy = 1'b1;
      if (stall_left > 0) begin
         rdy = 1'b0;
         stall_left--;
      end
      in_valid = v; in_first = f; in_disp_base = b; in_left = l; in_right = r;
      out_ready = rdy;
      #1;
      if (p_stall) begin
         chk("hold_disp", out_disp, p_disp);
         chk("hold_sad", out_sad, p_sad);
      end
      if (out_valid && !rdy) chk("stall_in_ready", in_ready, 0);
      p_stall = out_valid && !rdy;
      p_disp  = out_disp;
      p_sad   = out_sad;
      if (chk_lat) chk("out_valid_timing", out_valid, (q.size() > 0 && q[0].c + 4 == cyc));
      if (out_valid && rdy) begin
         if (q.size() == 0) chk("spurious_out_valid", out_valid, 0);
         else begin
            e = q.pop_front();
            chk("disp_row0", out_disp[7:0], e.d0);
            chk("disp_row1", out_disp[15:8], e.d1);
            chk("sad_row0", out_sad[15:0], e.s0);
            chk("sad_row1", out_sad[31:16], e.s1);
         end
      end
      accd = v && in_ready;
      if (accd) begin
         if (f) begin
            m_cnt  = 1;
            m_base = b;
         end else if (m_cnt < CMAX) m_cnt++;
         if (m_cnt == CMAX) begin
            e.d0 = 8'(m_base + e_d);
            e.d1 = 8'(m_base + e_d);
            e.s0 = 16'(e_s0);
            e.s1 = 16'(e_s1);
            e.c  = cyc;
            q.push_back(e);
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic beat(input logic f, input logic [7:0] b, input logic [CW-1:0] l,
                       input logic [CW-1:0] r);
      bit a;
      int tries;
      tries = 0;
      do begin
         step(1'b1, f, b, l, r, a);
         tries++;
      end while (!a && tries < 40);
      if (!a) begin
         n_cmp++;
         n_fail++;
         $error("FAIL accept_timeout: observed in_ready %0d, expected 1", in_ready);
      end
   endtask

   task automatic drain();
      bit a;
      int t;
      t = 0;
      while (q.size() > 0 && t < 40) begin
         step(1'b0, 1'b0, 8'd0, '0, '0, a);
         t++;
      end
      chk("drain_pending", q.size(), 0);
      repeat (4) step(1'b0, 1'b0, 8'd0, '0, '0, a);
   endtask

   initial begin
      bit a;
      rst_n = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_disp_base = '0;
      in_left = '0; in_right = '0; out_ready = 1'b1;
      m_cnt = 0; m_base = '0; chk_lat = 1'b0; stall_left = 0; p_stall = 1'b0;
      e_d = 0; e_s0 = 0; e_s1 = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_disp", out_disp, 0);
      chk("rst_out_sad", out_sad, 0);
      chk("rst_in_ready", in_ready, 1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk_lat = 1'b1;

      // Flat scene: every disparity ties at zero, lowest wins.
      e_d = 0; e_s0 = 0; e_s1 = 0;
      for (int n = 0; n < 18; n++) beat(n == 0, 8'd3, col_const(5), col_const(5));
      drain();

      // Right leads left by two columns.
      e_d = 2; e_s0 = 0; e_s1 = 0;
      for (int n = 0; n < 20; n++) beat(n == 0, 8'd10, col_ramp(n), col_ramp(n + 2));
      drain();

      // Shift of three with base 254 wraps to 1; ten-cycle sink stall mid-stream.
      chk_lat = 1'b0;
      e_d = 3; e_s0 = 0; e_s1 = 0;
      for (int n = 0; n < 22; n++) begin
         if (n == 19) stall_left = 10;
         beat(n == 0, 8'd254, col_ramp(n), col_ramp(n + 3));
      end

      // New pass right behind three in-flight results; rows now differ.
      e_d = 0; e_s0 = 90; e_s1 = 0;
      for (int n = 0; n < 18; n++) beat(n == 0, 8'd40, col_const(100), col_r5());
      drain();
      chk_lat = 1'b1;

      // Reset while three emitting beats are in flight.
      e_d = 0; e_s0 = 0; e_s1 = 0;
      for (int n = 0; n < 18; n++) beat(n == 0, 8'd7, col_const(5), col_const(5));
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_out_sad", out_sad, 0);
      q.delete();
      m_cnt = 0; m_base = '0; p_stall = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
      rst_n = 1'b1;
      repeat (6) step(1'b0, 1'b0, 8'd0, '0, '0, a);
      for (int n = 0; n < 6; n++) beat(1'b0, 8'd0, col_const(5), col_const(5));

      // Saturated difference: 81*511 per row.
      e_d = 0; e_s0 = 81 * 511; e_s1 = 81 * 511;
      for (int n = 0; n < 17; n++) beat(n == 0, 8'd200, col_const(511), col_const(0));
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
